mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001: Parameter COLS_PER_CYCLE, default 1, SHALL set the number of 32-bit columns processed per clock; legal values are 1, 2 and 4.
REQ-002: Parameter INV_ONLY, default 0, SHALL disable the forward datapath when 1; the mode input is then ignored and treated as 1.
REQ-003: clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004: rst_n, input, 1, synchronous active-low reset sampled on the clk rising edge.
REQ-005: in_valid, input, 1, the upstream block presents a state.
REQ-006: in_ready, output, 1, the engine accepts a state this cycle.
REQ-007: in_mode, input, 1, 0 selects forward MixColumns and 1 selects InvMixColumns; it is sampled with in_data.
REQ-008: in_data, input, 128, the AES state; column c occupies bits [127-32c -: 32], with row 0 in the MSB byte of each column.
REQ-009: out_valid, output, 1, out_data holds a completed result.
REQ-010: out_ready, input, 1, the downstream block accepts the result.
REQ-011: out_data, output, 128, the transformed state, using the same column and row layout as in_data.
REQ-012: busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013: The engine SHALL use the states IDLE, CALC and DONE, encoded in a registered state variable.
REQ-014: In IDLE, in_ready SHALL be 1; on in_valid && in_ready, the engine SHALL latch in_data and in_mode, clear the column counter to 0 and move to CALC.
REQ-015: In CALC, the engine SHALL transform columns col_cnt through col_cnt+COLS_PER_CYCLE-1 each cycle, write them in place and advance col_cnt by COLS_PER_CYCLE.
REQ-016: When the last column group is written, the engine SHALL move to DONE; CALC therefore lasts 4/COLS_PER_CYCLE cycles (4, 2 or 1).
REQ-017: Latency from the accept edge to out_valid=1 SHALL be exactly 4/COLS_PER_CYCLE cycles.
REQ-018: In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready=1.
REQ-019: On out_valid && out_ready, the engine SHALL return to IDLE.
REQ-020: in_ready SHALL be 0 in CALC and in DONE; no new state is accepted until the handshake completes, so throughput is at most one state per 4/COLS_PER_CYCLE+1 cycles.
REQ-021: Forward column math SHALL be b0=2a0^3a1^a2^a3, rotated per row (b1=a0^2a1^3a2^a3, and so on).
REQ-022: Inverse column math SHALL be b0=Ea0^Ba1^Da2^9a3, rotated per row (b1=9a0^Ea1^Ba2^Da3, and so on).
REQ-023: Multiplication SHALL be in GF(2^8) modulo x^8+x^4+x^3+x+1, built from xtime chains; no 256-entry lookup tables.
REQ-024: All arithmetic SHALL be 8-bit XOR; there are no carries and no width growth.
REQ-025: in_valid and in_mode changes while the engine is not in IDLE SHALL have no effect.
REQ-026: out_data outside DONE SHALL equal the internal state register; downstream logic must qualify it with out_valid.
REQ-027: When INV_ONLY=1, the forward multiplier logic SHALL NOT be instantiated.

Reset
REQ-028: When rst_n=0 at a clk edge, the state SHALL go to IDLE and col_cnt, the state register and out_data SHALL go to 0.
REQ-029: During reset, out_valid=0, busy=0 and in_ready=0.
REQ-030: On the first cycle after rst_n returns high, in_ready SHALL be 1.
REQ-031: Reset asserted in CALC or DONE SHALL abort the operation; no out_valid pulse SHALL follow and the result SHALL be discarded.

Verification
REQ-032: Forward, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, mode 0 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising exactly 4 cycles after accept.
REQ-033: Inverse, COLS_PER_CYCLE=4: in_data=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, mode 1 -> out_data=db135345_f20a225c_d4d4d4d5_2d26314c, with a latency of 1 cycle.
REQ-034: Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stays stable, in_ready=0 and a second in_valid is ignored; the output is accepted on the first cycle out_ready=1.
REQ-035: Reset mid-CALC (COLS_PER_CYCLE=1, after 2 cycles) -> the next cycle shows all outputs 0 and state IDLE, and no out_valid pulse occurs.
REQ-036: Round trip: 1000 random states, forward then inverse, for each COLS_PER_CYCLE value -> the result equals the original input every time.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: transforms a 128-bit state in place,
// COLS_PER_CYCLE columns per clock, behind valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for a state to latch
// CALC  | transforming column groups in place
// DONE  | out_valid high, result held until out_ready
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_ONLY       = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] GRP_STEP = 2'(COLS_PER_CYCLE);

    state_t       state;
    logic [1:0]   col_cnt;
    logic         mode_q;
    logic [127:0] st_q;
    logic [127:0] st_nxt;

    logic [1:0]   idx     [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Coefficients 9/B/D/E share one x2/x4/x8 chain per byte.
    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] b [4];
        logic [7:0] x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        {b[0], b[1], b[2], b[3]} = a;
        for (int k = 0; k < 4; k++) begin
            x2    = xt(b[k]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[k] = x8 ^ b[k];
            mb[k] = x8 ^ x2 ^ b[k];
            md[k] = x8 ^ x4 ^ b[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        logic [31:0] inv_r;
        assign idx[l]    = col_cnt + 2'(l);
        // Column c lives at bits [(3-c)*32 +: 32]; 3-c is ~c for two bits.
        assign col_in[l] = st_q[{~idx[l], 5'd0} +: 32];
        assign inv_r     = inv_col(col_in[l]);
        if (INV_ONLY) begin : g_inv
            assign col_out[l] = inv_r;
        end else begin : g_fwd
            logic [31:0] fwd_r;
            assign fwd_r      = fwd_col(col_in[l]);
            assign col_out[l] = mode_q ? inv_r : fwd_r;
        end
    end

    always_comb begin
        st_nxt = st_q;
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
            st_nxt[{~idx[l], 5'd0} +: 32] = col_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            col_cnt   <= 2'd0;
            mode_q    <= 1'b0;
            st_q      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        st_q     <= in_data;
                        mode_q   <= INV_ONLY ? 1'b1 : in_mode;
                        col_cnt  <= 2'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    st_q    <= st_nxt;
                    col_cnt <= col_cnt + GRP_STEP;
                    if (col_cnt == LAST_GRP) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data = st_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Drives four engine variants (1/2/4 columns per cycle, plus inverse-only) with shared
// stimulus and compares each against a GF(2^8) matrix-product reference model.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_mode, out_ready;
    logic [127:0] in_data;
    logic         ir [4];
    logic         ov [4];
    logic         bz [4];
    logic [127:0] od [4];

    int checks = 0;
    int errors = 0;
    int lat_exp [4] = '{4, 2, 1, 2};
    bit inv_only [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_ONLY(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_ONLY(1'b0)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_ONLY(1'b0)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_ONLY(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bz[3]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product: row r uses the base coefficient row rotated right by r.
    function automatic logic [127:0] mix(input logic [127:0] d, input logic inv);
        logic [7:0] base [4];
        logic [7:0] a [4];
        logic [7:0] s;
        logic [127:0] r = '0;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = d[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                s = 8'h00;
                for (int k = 0; k < 4; k++) s = s ^ gmul(base[(k - row + 4) % 4], a[k]);
                r[127 - 32*c - 8*row -: 8] = s;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accepts d on all four engines, checks latency and result, then completes the handshake.
    task automatic xact(input logic [127:0] d, input logic m, input logic [127:0] exp [4]);
        int lat [4] = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) chk("in_ready_idle", 128'(ir[i]), 128'd1);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_mode  = 1'($urandom_range(0, 1));
            in_data  = rnd128();
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (ov[i] === 1'b1 && lat[i] == 0) lat[i] = c;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("latency", 128'(lat[i]), 128'(lat_exp[i]));
            chk("out_data", od[i], exp[i]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) chk("out_valid_after_hs", 128'(ov[i]), 128'd0);
    endtask

    logic [127:0] e [4];
    logic [127:0] x, f;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", 128'(ir[i]), 128'd0);
            chk("rst_out_valid", 128'(ov[i]), 128'd0);
            chk("rst_busy", 128'(bz[i]), 128'd0);
            chk("rst_out_data", od[i], 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) chk("ready_after_rst", 128'(ir[i]), 128'd1);

        // Known forward and inverse vectors; the inverse-only engine ignores mode 0.
        x = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        f = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        e = '{f, f, f, mix(x, 1'b1)};
        xact(x, 1'b0, e);
        x = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        f = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        e = '{f, f, f, f};
        xact(x, 1'b1, e);

        // Backpressure: result held for 5 cycles while a second state is offered.
        x = rnd128();
        in_data = x; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("bp_valid", 128'(ov[i]), 128'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); in_data = rnd128();
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                chk("bp_data", od[i], mix(x, inv_only[i]));
                chk("bp_in_ready", 128'(ir[i]), 128'd0);
                chk("bp_valid_hold", 128'(ov[i]), 128'd1);
                chk("bp_busy", 128'(bz[i]), 128'd1);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hs_valid", 128'(ov[i]), 128'd0);
            chk("bp_hs_ready", 128'(ir[i]), 128'd1);
            chk("bp_hs_busy", 128'(bz[i]), 128'd0);
        end
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("bp_no_second", 128'(ov[i] | bz[i]), 128'd0);

        // Reset two cycles into CALC aborts the operation.
        in_data = rnd128(); in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_calc_busy", 128'(bz[0]), 128'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_valid", 128'(ov[i]), 128'd0);
            chk("abort_busy", 128'(bz[i]), 128'd0);
            chk("abort_ready", 128'(ir[i]), 128'd0);
            chk("abort_data", od[i], 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) chk("abort_ready_back", 128'(ir[i]), 128'd1);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("abort_no_valid", 128'(ov[i] | bz[i]), 128'd0);

        // Round trip: forward then inverse must restore every random state.
        for (int n = 0; n < 1000; n++) begin
            x = rnd128();
            f = mix(x, 1'b0);
            e = '{f, f, f, mix(x, 1'b1)};
            xact(x, 1'b0, e);
            e = '{x, x, x, x};
            xact(f, 1'b1, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
